// File: rtl/fft_pingpong_buffer.sv
// Two-bank ping-pong sample buffer: a stream fills one bank (optionally in
// bit-reversed order) while the FFT engine randomly reads the other bank.
module fft_pingpong_buffer #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 6,
    parameter bit          BITREV_WR = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_add,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_done,
    output logic              frame_ready,
    output logic [ADDR_W:0]   wr_level,
    output logic              err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned MEM_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DEPTH - 1);

    // Reverse the bit order of a sample index
    function automatic logic [ADDR_W-1:0] f_bitrev(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        for (int i = 0; i < int'(ADDR_W); i++) begin
            r[i] = a[ADDR_W-1-i];
        end
        return r;
    endfunction

    logic [DATA_W-1:0] r_mem [2*DEPTH];

    logic [1:0]        r_full;
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [ADDR_W-1:0] r_wr_cnt;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_err;

    logic              w_wr_ready;
    logic              w_frame_ready;
    logic              w_wr_acc;
    logic              w_wr_last;
    logic              w_rd_acc;
    logic              w_release;
    logic              w_proto_err;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [1:0]        w_full_nxt;

    // Handshake decode from current ownership state
    always_comb begin
        w_wr_ready    = ~r_full[r_wr_bank];
        w_frame_ready = r_full[r_rd_bank];
        w_wr_acc      = wr_valid & w_wr_ready;
        w_wr_last     = w_wr_acc & (r_wr_cnt == LAST_CNT);
        w_rd_acc      = rd_en & w_frame_ready;
        w_release     = rd_done & w_frame_ready;
        w_proto_err   = (rd_en | rd_done) & ~w_frame_ready;
        w_wr_addr     = BITREV_WR ? f_bitrev(r_wr_cnt) : r_wr_cnt;
    end

    // Ownership flags: completion and release always target distinct banks
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_last) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_release) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    // Sample storage, not reset
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[MEM_W'({r_wr_bank, w_wr_addr})] <= wr_data;
        end
    end

    // Control state, write counter and registered read port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_full     <= 2'b00;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_wr_cnt   <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_full     <= w_full_nxt;
            r_rd_valid <= w_rd_acc;
            if (w_wr_acc) begin
                r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
            end
            if (w_wr_last) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (w_release) begin
                r_rd_bank <= ~r_rd_bank;
            end
            if (w_rd_acc) begin
                r_rd_data <= r_mem[MEM_W'({r_rd_bank, rd_add})];
            end
            if (w_proto_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign wr_ready    = w_wr_ready;
    assign frame_ready = w_frame_ready;
    assign wr_level    = {1'b0, r_wr_cnt};
    assign rd_data     = r_rd_data;
    assign rd_valid    = r_rd_valid;
    assign err         = r_err;

endmodule

// File: tb/tb_fft_pingpong_buffer.sv
// Directed bench for fft_pingpong_buffer with the 64-point, bit-reversed default.
module tb_fft_pingpong_buffer;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 6;

    logic              clk;
    logic              reset_n;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_add;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_done;
    logic              frame_ready;
    logic [ADDR_W:0]   wr_level;
    logic              err;

    int n_vec;
    int n_err;

    fft_pingpong_buffer #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .BITREV_WR(1'b1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .rd_en      (rd_en),
        .rd_add     (rd_add),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_done    (rd_done),
        .frame_ready(frame_ready),
        .wr_level   (wr_level),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr_valid = 1'b0;
        rd_en    = 1'b0;
        rd_done  = 1'b0;
    endtask

    // Stream n samples base+k with wr_valid held high
    task automatic write_n(input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            wr_valid = 1'b1;
            wr_data  = base + 32'(k);
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
        chk({tag, "_frame_ready"}, 32'(frame_ready), 32'd0);
        chk({tag, "_wr_level"}, 32'(wr_level), 32'd0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_rd_data"}, rd_data, 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset_n  = 1'b0;
        wr_data  = '0;
        rd_add   = '0;
        idle();
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Frame 1 into bank 0
        write_n(32'h0000_0000, 20);
        chk("f1_level20", 32'(wr_level), 32'd20);
        write_n(32'h0000_0014, 44);
        chk("f1_frame_ready", 32'(frame_ready), 32'd1);
        chk("f1_wr_level", 32'(wr_level), 32'd0);
        chk("f1_wr_ready", 32'(wr_ready), 32'd1);

        // Pipelined reads, bit-reversed placement
        rd_en = 1'b1; rd_add = 6'd1;
        tick();
        chk("rd1_valid", 32'(rd_valid), 32'd1);
        chk("rd1_data", rd_data, 32'h0000_0020);
        rd_add = 6'd6;
        tick();
        chk("rd6_valid", 32'(rd_valid), 32'd1);
        chk("rd6_data", rd_data, 32'h0000_0018);
        rd_en = 1'b0;
        tick();
        chk("rd_idle_valid", 32'(rd_valid), 32'd0);
        chk("rd_idle_hold", rd_data, 32'h0000_0018);

        // Frame 2 into bank 1, then back-pressure
        write_n(32'h0000_0100, 64);
        chk("f2_wr_ready", 32'(wr_ready), 32'd0);
        chk("f2_wr_level", 32'(wr_level), 32'd0);
        wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF;
        tick();
        wr_valid = 1'b0;
        chk("bp_wr_level", 32'(wr_level), 32'd0);
        chk("bp_wr_ready", 32'(wr_ready), 32'd0);
        chk("bp_err", 32'(err), 32'd0);
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("rel_wr_ready", 32'(wr_ready), 32'd1);
        chk("rel_frame_ready", 32'(frame_ready), 32'd1);

        // Back-to-back reads of bank 1, release on the last one
        rd_en = 1'b1; rd_add = 6'd0;
        tick();
        chk("b2b0_valid", 32'(rd_valid), 32'd1);
        chk("b2b0_data", rd_data, 32'h0000_0100);
        rd_add = 6'd1;
        tick();
        chk("b2b1_valid", 32'(rd_valid), 32'd1);
        chk("b2b1_data", rd_data, 32'h0000_0120);
        rd_add = 6'd2;
        tick();
        chk("b2b2_valid", 32'(rd_valid), 32'd1);
        chk("b2b2_data", rd_data, 32'h0000_0110);
        rd_add = 6'd3; rd_done = 1'b1;
        tick();
        idle();
        chk("b2b3_valid", 32'(rd_valid), 32'd1);
        chk("b2b3_data", rd_data, 32'h0000_0130);
        chk("b2b3_frame_ready", 32'(frame_ready), 32'd0);
        tick();
        chk("b2b_after_valid", 32'(rd_valid), 32'd0);

        // Fill both banks, release bank 0 so the reader owns bank 1
        write_n(32'h0000_0200, 64);
        write_n(32'h0000_0300, 64);
        chk("both_full_wr_ready", 32'(wr_ready), 32'd0);
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;

        // Writer completes bank 0 in the same edge the reader releases bank 1
        write_n(32'h0000_0400, 63);
        chk("same_pre_level", 32'(wr_level), 32'd63);
        wr_valid = 1'b1; wr_data = 32'h0000_043F; rd_done = 1'b1;
        tick();
        idle();
        chk("same_frame_ready", 32'(frame_ready), 32'd1);
        chk("same_wr_ready", 32'(wr_ready), 32'd1);
        chk("same_wr_level", 32'(wr_level), 32'd0);
        rd_en = 1'b1; rd_add = 6'd1;
        tick();
        rd_en = 1'b0;
        chk("same_rd_data", rd_data, 32'h0000_0420);

        // Protocol errors with no frame owned
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("empty_frame_ready", 32'(frame_ready), 32'd0);
        rd_en = 1'b1; rd_add = 6'd0;
        tick();
        rd_en = 1'b0;
        chk("err_rd_valid", 32'(rd_valid), 32'd0);
        chk("err_set", 32'(err), 32'd1);
        chk("err_rd_hold", rd_data, 32'h0000_0420);
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("err_done_wr_ready", 32'(wr_ready), 32'd1);
        chk("err_done_frame_ready", 32'(frame_ready), 32'd0);

        // Normal frame after an error
        write_n(32'h0000_0500, 64);
        chk("post_err_frame_ready", 32'(frame_ready), 32'd1);
        rd_en = 1'b1; rd_add = 6'd63;
        tick();
        rd_en = 1'b0;
        chk("post_err_rd_data", rd_data, 32'h0000_053F);
        chk("post_err_sticky", 32'(err), 32'd1);

        // Asynchronous reset mid-frame
        write_n(32'h0000_0550, 20);
        chk("pre_rst_level", 32'(wr_level), 32'd20);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        write_n(32'h0000_0600, 63);
        chk("rst_f_level63", 32'(wr_level), 32'd63);
        chk("rst_f_not_ready", 32'(frame_ready), 32'd0);
        write_n(32'h0000_063F, 1);
        chk("rst_f_ready", 32'(frame_ready), 32'd1);
        chk("rst_f_level0", 32'(wr_level), 32'd0);
        rd_en = 1'b1; rd_add = 6'd2;
        tick();
        rd_en = 1'b0;
        chk("rst_f_rd_valid", 32'(rd_valid), 32'd1);
        chk("rst_f_rd_data", rd_data, 32'h0000_0610);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
